// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES decryption datapath: state width, byte
// count, AES-128 round count and an MSB-first byte-slice helper.
package aes_dec_pkg;

   localparam int STATE_W   = 128;
   localparam int NB        = 16;
   localparam int NR_AES128 = 10;
   localparam int ROUND_W   = 4;

   // Byte 0 occupies bits 0:7, byte k occupies bits 8k:8k+7.
   typedef logic [0:STATE_W-1] state_t;

   function automatic logic [7:0] state_byte(input state_t s, input int k);
      return s[8*k +: 8];
   endfunction

endpackage

// File: rtl/inv_ark_fifo2.sv
// Two-entry in-order buffer between the AddRoundKey XOR and the downstream
// stage. The head entry stays put until it is popped, so the output is
// stable under backpressure. count_next exposes the occupancy after the
// current edge, which the parent uses to register its ready signal.
module inv_ark_fifo2 #(
   parameter int W = 133
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic [1:0]   count_next
);

   logic [W-1:0] head_q, head_d;
   logic [W-1:0] tail_q, tail_d;
   logic [1:0]   count_q, count_d;
   logic         do_push;
   logic         do_pop;

   // Next-state for the two slots and the occupancy count.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      do_pop  = pop && (count_q != 2'd0);
      do_push = push && (count_q != 2'd2);
      case ({do_push, do_pop})
         2'b10: begin
            if (count_q == 2'd0) head_d = push_data;
            else                 tail_d = push_data;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               head_d = push_data;
            end else begin
               head_d = tail_q;
               tail_d = push_data;
            end
         end
         default: ;
      endcase
   end

   // Slot and count registers; reset empties the buffer and zeroes the head.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign out_valid  = (count_q != 2'd0);
   assign out_data   = head_q;
   assign count_next = count_d;

endmodule

// File: rtl/inv_add_round_key.sv
// Inverse-cipher AddRoundKey stage. Holds NR+1 round keys written by the
// key expansion, XORs the incoming state with the key selected by its
// round index and hands the result to InvMixColumns through a two-entry
// buffer. Round indices beyond NR pass the state through untouched and
// raise a sticky error flag.
module inv_add_round_key #(
   parameter int NR      = 10,
   parameter int ROUND_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               key_wr_en,
   input  logic [ROUND_W-1:0] key_wr_idx,
   input  logic [0:127]       key_wr_data,
   input  logic               key_clear,
   output logic               keys_ready,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [0:127]       in_state,
   input  logic [ROUND_W-1:0] in_round,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [0:127]       out_state,
   output logic [ROUND_W-1:0] out_round,
   output logic               out_mix_en,
   output logic               err_round
);

   import aes_dec_pkg::*;

   localparam int ENTRY_W = STATE_W + ROUND_W + 1;

   state_t               key_store_q [0:NR];
   state_t               key_store_d [0:NR];
   logic [NR:0]          loaded_q, loaded_d;
   logic                 err_q, err_d;
   logic                 in_ready_q, in_ready_d;
   logic                 accept;
   logic                 round_ok;
   logic                 mix_en;
   state_t               key_sel;
   state_t               xor_state;
   logic [ENTRY_W-1:0]   push_entry;
   logic [ENTRY_W-1:0]   head_entry;
   logic [1:0]           count_next;

   assign accept   = in_valid && in_ready_q;
   assign round_ok = (in_round <= ROUND_W'(NR));
   assign mix_en   = (in_round >= ROUND_W'(1)) && (in_round <= ROUND_W'(NR - 1));

   // Key store updates; a clear drops every loaded flag even if a write lands the same cycle.
   always_comb begin
      key_store_d = key_store_q;
      loaded_d    = loaded_q;
      if (key_wr_en && (key_wr_idx <= ROUND_W'(NR))) begin
         key_store_d[key_wr_idx] = key_wr_data;
         loaded_d[key_wr_idx]    = 1'b1;
      end
      if (key_clear) loaded_d = '0;
   end

   // Key selection from the pre-write store contents, then bytewise XOR with the state.
   always_comb begin
      key_sel   = round_ok ? key_store_q[in_round] : '0;
      xor_state = '0;
      for (int k = 0; k < NB; k++) begin
         xor_state[8*k +: 8] = state_byte(in_state, k) ^ state_byte(key_sel, k);
      end
   end

   // Sticky bad-round flag and a registered ready derived from next-cycle occupancy.
   always_comb begin
      err_d      = err_q || (accept && !round_ok);
      in_ready_d = (&loaded_d) && (count_next != 2'd2);
   end

   // Key store, loaded flags, error flag and ready register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= NR; i++) key_store_q[i] <= '0;
         loaded_q   <= '0;
         err_q      <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         for (int i = 0; i <= NR; i++) key_store_q[i] <= key_store_d[i];
         loaded_q   <= loaded_d;
         err_q      <= err_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign push_entry = {xor_state, in_round, mix_en && round_ok};

   inv_ark_fifo2 #(
      .W (ENTRY_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (accept),
      .push_data  (push_entry),
      .pop        (out_ready),
      .out_valid  (out_valid),
      .out_data   (head_entry),
      .count_next (count_next)
   );

   assign out_state  = head_entry[ENTRY_W-1 -: STATE_W];
   assign out_round  = head_entry[ROUND_W:1];
   assign out_mix_en = head_entry[0];
   assign keys_ready = &loaded_q;
   assign in_ready   = in_ready_q;
   assign err_round  = err_q;

endmodule

// File: tb/tb_inv_add_round_key.sv
// Scoreboard bench for inv_add_round_key: the driver predicts each accepted
// transfer from a plain key-array model, a separate monitor pops and
// compares whenever the DUT hands an output downstream.
module tb_inv_add_round_key;

   import aes_dec_pkg::*;

   localparam int NR = 10;

   typedef struct {
      state_t     state;
      logic [3:0] round;
      logic       mix;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_wr_en;
   logic [3:0] key_wr_idx;
   state_t     key_wr_data;
   logic       key_clear;
   logic       keys_ready;
   logic       in_valid;
   logic       in_ready;
   state_t     in_state;
   logic [3:0] in_round;
   logic       out_valid;
   logic       out_ready;
   state_t     out_state;
   logic [3:0] out_round;
   logic       out_mix_en;
   logic       err_round;

   exp_t   sb[$];
   state_t model_key [0:NR];
   int     checks   = 0;
   int     failures = 0;

   inv_add_round_key #(.NR(NR), .ROUND_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_wr_en   (key_wr_en),
      .key_wr_idx  (key_wr_idx),
      .key_wr_data (key_wr_data),
      .key_clear   (key_clear),
      .keys_ready  (keys_ready),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_state    (in_state),
      .in_round    (in_round),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_state   (out_state),
      .out_round   (out_round),
      .out_mix_en  (out_mix_en),
      .err_round   (err_round)
   );

   always #5 clk = ~clk;

   function automatic exp_t reference(input state_t st, input logic [3:0] r);
      exp_t e;
      state_t k;
      k = (int'(r) <= NR) ? model_key[r] : '0;
      e.state = st ^ k;
      e.round = r;
      e.mix   = (int'(r) >= 1) && (int'(r) <= NR - 1);
      return e;
   endfunction

   function automatic state_t rand_state();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // One cycle of stimulus, starting just after a rising edge.
   task automatic applyStimulus(input logic v, input state_t st, input logic [3:0] r, input logic ordy,
                                input logic wr, input logic [3:0] widx, input state_t wdata,
                                input logic clr, output logic accepted);
      in_valid    = v;
      in_state    = st;
      in_round    = r;
      out_ready   = ordy;
      key_wr_en   = wr;
      key_wr_idx  = widx;
      key_wr_data = wdata;
      key_clear   = clr;
      @(negedge clk);
      accepted = v && in_ready;
      if (accepted) sb.push_back(reference(st, r));
      if (wr && int'(widx) <= NR) model_key[widx] = wdata;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input state_t st, input logic [3:0] r, input logic ordy, output logic accepted);
      applyStimulus(1'b1, st, r, ordy, 1'b0, 4'd0, '0, 1'b0, accepted);
   endtask

   task automatic idle(input int n, input logic ordy);
      logic a;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 4'd0, ordy, 1'b0, 4'd0, '0, 1'b0, a);
   endtask

   task automatic loadKey(input logic [3:0] idx, input state_t data);
      logic a;
      applyStimulus(1'b0, '0, 4'd0, 1'b1, 1'b1, idx, data, 1'b0, a);
   endtask

   task automatic loadAllKeys();
      loadKey(4'd0, 128'h000102030405060708090a0b0c0d0e0f);
      for (int i = 1; i < NR; i++) loadKey(4'(i), rand_state());
      loadKey(4'(NR), 128'h13111d7fe3944a17f307a78b4d2b30c5);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 20) begin
         idle(1, 1'b1);
         n++;
      end
      checkOutput("drain_empty", 128'(sb.size()), 128'd0);
   endtask

   task automatic doReset();
      rst = 1'b1;
      #1;
      sb.delete();
      for (int i = 0; i <= NR; i++) model_key[i] = '0;
      checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
      checkOutput("rst_in_ready", 128'(in_ready), 128'd0);
      checkOutput("rst_keys_ready", 128'(keys_ready), 128'd0);
      checkOutput("rst_err_round", 128'(err_round), 128'd0);
      checkOutput("rst_out_state", out_state, 128'd0);
      checkOutput("rst_out_round", 128'(out_round), 128'd0);
      checkOutput("rst_out_mix_en", 128'(out_mix_en), 128'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: compare every handed-off output with the next prediction, and hold-stability under stall.
   initial begin : monitor
      exp_t       e;
      logic       stalled;
      state_t     held_state;
      logic [3:0] held_round;
      logic       held_mix;
      stalled = 1'b0;
      held_state = '0;
      held_round = '0;
      held_mix = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               checkOutput("hold_state", out_state, held_state);
               checkOutput("hold_round", 128'(out_round), 128'(held_round));
               checkOutput("hold_mix", 128'(out_mix_en), 128'(held_mix));
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checkOutput("unexpected_output", 128'(out_valid), 128'd0);
               end else begin
                  e = sb.pop_front();
                  checkOutput("sb_state", out_state, e.state);
                  checkOutput("sb_round", 128'(out_round), 128'(e.round));
                  checkOutput("sb_mix_en", 128'(out_mix_en), 128'(e.mix));
               end
            end
            stalled    = out_valid && !out_ready;
            held_state = out_state;
            held_round = out_round;
            held_mix   = out_mix_en;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : driver
      logic   acc;
      int     n_acc;
      state_t st;
      state_t new_key;

      rst = 1'b1;
      in_valid = 1'b0;
      in_state = '0;
      in_round = '0;
      out_ready = 1'b1;
      key_wr_en = 1'b0;
      key_wr_idx = '0;
      key_wr_data = '0;
      key_clear = 1'b0;
      for (int i = 0; i <= NR; i++) model_key[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      doReset();

      // Only ten of eleven slots loaded: stage must not accept.
      loadKey(4'd0, 128'h000102030405060708090a0b0c0d0e0f);
      for (int i = 1; i < NR; i++) loadKey(4'(i), rand_state());
      checkOutput("ten_keys_ready", 128'(keys_ready), 128'd0);
      checkOutput("ten_keys_in_ready", 128'(in_ready), 128'd0);
      loadKey(4'(NR), 128'h13111d7fe3944a17f307a78b4d2b30c5);
      checkOutput("all_keys_ready", 128'(keys_ready), 128'd1);
      checkOutput("all_keys_in_ready", 128'(in_ready), 128'd1);

      // FIPS-197 C.1 final round.
      send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 4'd10, 1'b1, acc);
      checkOutput("fips_accept", 128'(acc), 128'd1);
      checkOutput("fips_latency_valid", 128'(out_valid), 128'd1);
      checkOutput("fips_state", out_state, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
      checkOutput("fips_mix_en", 128'(out_mix_en), 128'd0);

      send(128'h00102030405060708090a0b0c0d0e0f0, 4'd0, 1'b1, acc);
      checkOutput("round0_state", out_state, 128'h00112233445566778899aabbccddeeff);
      checkOutput("round0_mix_en", 128'(out_mix_en), 128'd0);

      send(rand_state(), 4'd5, 1'b1, acc);
      checkOutput("round5_mix_en", 128'(out_mix_en), 128'd1);

      // Random traffic with random backpressure.
      for (int i = 0; i < 80; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), rand_state(), 4'($urandom_range(0, NR)),
                       1'($urandom_range(0, 3) != 0), 1'b0, 4'd0, '0, 1'b0, acc);
      end
      drain();

      // Backpressure: five stalled cycles, three items offered.
      n_acc = 0;
      for (int c = 0; c < 5; c++) begin
         if (n_acc < 3) begin
            send(rand_state(), 4'($urandom_range(1, 9)), 1'b0, acc);
            if (acc) n_acc++;
         end else begin
            idle(1, 1'b0);
         end
      end
      checkOutput("bp_accepted", 128'(n_acc), 128'd2);
      checkOutput("bp_in_ready", 128'(in_ready), 128'd0);
      idle(1, 1'b1);
      checkOutput("bp_release_second", 128'(out_valid), 128'd1);
      idle(1, 1'b1);
      checkOutput("bp_release_empty", 128'(out_valid), 128'd0);
      checkOutput("bp_sb_empty", 128'(sb.size()), 128'd0);

      // Writing slot 3 while accepting round 3 uses the old key; the next one uses the new key.
      new_key = rand_state();
      applyStimulus(1'b1, rand_state(), 4'd3, 1'b1, 1'b1, 4'd3, new_key, 1'b0, acc);
      checkOutput("rbw_accept", 128'(acc), 128'd1);
      send(rand_state(), 4'd3, 1'b1, acc);
      drain();

      // Clear flags with one entry buffered: ready drops, buffered data still drains.
      send(rand_state(), 4'd7, 1'b0, acc);
      applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b0, 4'd0, '0, 1'b1, acc);
      checkOutput("clear_in_ready", 128'(in_ready), 128'd0);
      checkOutput("clear_keys_ready", 128'(keys_ready), 128'd0);
      checkOutput("clear_buffered_valid", 128'(out_valid), 128'd1);
      send(rand_state(), 4'd2, 1'b0, acc);
      checkOutput("clear_no_accept", 128'(acc), 128'd0);
      drain();
      loadAllKeys();

      // Out-of-range round: passthrough, no mix, sticky error.
      checkOutput("err_before", 128'(err_round), 128'd0);
      st = rand_state();
      send(st, 4'd12, 1'b0, acc);
      checkOutput("bad_round_state", out_state, st);
      checkOutput("bad_round_mix_en", 128'(out_mix_en), 128'd0);
      checkOutput("bad_round_err", 128'(err_round), 128'd1);
      drain();
      send(rand_state(), 4'd4, 1'b1, acc);
      idle(3, 1'b1);
      checkOutput("err_sticky", 128'(err_round), 128'd1);
      drain();

      // Reset with two entries buffered.
      send(rand_state(), 4'd1, 1'b0, acc);
      send(rand_state(), 4'd9, 1'b0, acc);
      doReset();
      idle(2, 1'b1);
      checkOutput("post_rst_out_valid", 128'(out_valid), 128'd0);
      loadAllKeys();
      send(rand_state(), 4'd6, 1'b1, acc);
      send(rand_state(), 4'd10, 1'b1, acc);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
